// File: rtl/wb_stage_p.sv
// wb_stage_p: Beta write-back stage. Holds one retiring instruction, waits for load data with a
// timeout, and drives the register-file write port. Optional macro WB_BYPASS_EN adds a byp_* write copy.
module wb_stage_p #(
  parameter int DATA_W      = 32,
  parameter int RA_W        = 5,
  parameter int ZERO_REG    = 31,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_y,
  input  logic [1:0]        in_wd_sel,
  input  logic              in_werf,
  input  logic [RA_W-1:0]   in_rc,
  input  logic              flush,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data,
  output logic              busy,
  output logic              mem_timeout
`ifdef WB_BYPASS_EN
  ,
  output logic              byp_valid,
  output logic [RA_W-1:0]   byp_addr,
  output logic [DATA_W-1:0] byp_data
`endif
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(MEM_TIMEOUT);
  localparam logic [RA_W-1:0]  ZR     = RA_W'(ZERO_REG);

  typedef enum logic [1:0] {
    S_EMPTY    = 2'd0,
    S_FULL     = 2'd1,
    S_WAIT_MEM = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mem_timeout;
  logic [DATA_W-1:0]  r_pc;
  logic [DATA_W-1:0]  r_y;
  logic [1:0]         r_sel;
  logic               r_werf;
  logic [RA_W-1:0]    r_rc;

  logic               w_wait;
  logic               w_qual;
  logic               w_xfer;
  logic               w_timeout;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [DATA_W-1:0]  w_data;

  assign w_wait    = (r_state == S_WAIT_MEM);
  assign w_qual    = (r_state == S_FULL) || (w_wait && mem_rd_valid);
  assign in_ready  = !rst && !flush && (!w_wait || mem_rd_valid);
  assign w_xfer    = in_valid && in_ready;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  // The cycle that would bring the wait count to MEM_TIMEOUT is the last one allowed.
  assign w_timeout = (MEM_TIMEOUT != 0) && w_wait && !mem_rd_valid && (w_cnt_inc == TO_VAL);

  assign rf_we       = !rst && w_qual && r_werf && (r_rc != ZR) && !flush && (r_sel != 2'd3);
  assign rf_w_addr   = r_rc;
  assign rf_w_data   = w_data;
  assign busy        = !rst && (r_state != S_EMPTY);
  assign mem_timeout = r_mem_timeout;

  // Result select; load data is passed straight through in its response cycle.
  always_comb begin
    w_data = '0;
    case (r_sel)
      2'd0:    w_data = mem_rd;
      2'd1:    w_data = r_y;
      2'd2:    w_data = r_pc;
      default: w_data = '0;
    endcase
  end

  // Entry register, state and load-timeout tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_EMPTY;
      r_cnt         <= '0;
      r_mem_timeout <= 1'b0;
      r_pc          <= '0;
      r_y           <= '0;
      r_sel         <= 2'd0;
      r_werf        <= 1'b0;
      r_rc          <= '0;
    end else if (flush) begin
      r_state <= S_EMPTY;
      r_cnt   <= '0;
      r_pc    <= '0;
      r_y     <= '0;
      r_sel   <= 2'd0;
      r_werf  <= 1'b0;
      r_rc    <= '0;
    end else if (w_xfer) begin
      r_state <= (in_wd_sel == 2'd0) ? S_WAIT_MEM : S_FULL;
      r_cnt   <= '0;
      r_pc    <= in_pc;
      r_y     <= in_y;
      r_sel   <= in_wd_sel;
      r_werf  <= in_werf;
      r_rc    <= in_rc;
    end else if (w_wait && !mem_rd_valid) begin
      if (w_timeout) begin
        r_state       <= S_EMPTY;
        r_cnt         <= '0;
        r_mem_timeout <= 1'b1;
      end else if (MEM_TIMEOUT != 0) begin
        r_cnt <= w_cnt_inc;
      end else begin
        r_cnt <= r_cnt;
      end
    end else begin
      r_state <= S_EMPTY;
      r_cnt   <= '0;
    end
  end

`ifdef WB_BYPASS_EN
  logic              r_byp_valid;
  logic [RA_W-1:0]   r_byp_addr;
  logic [DATA_W-1:0] r_byp_data;

  assign byp_valid = r_byp_valid;
  assign byp_addr  = r_byp_addr;
  assign byp_data  = r_byp_data;

  // One-cycle-delayed copy of the last register-file write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byp_valid <= 1'b0;
      r_byp_addr  <= '0;
      r_byp_data  <= '0;
    end else begin
      r_byp_valid <= rf_we;
      if (rf_we) begin
        r_byp_addr <= rf_w_addr;
        r_byp_data <= rf_w_data;
      end else begin
        r_byp_addr <= r_byp_addr;
        r_byp_data <= r_byp_data;
      end
    end
  end
`endif

endmodule
